// File: rtl/div_seq.sv
// Multi-cycle DIV/DIVU sequencer: 32-iteration restoring divider with pipeline stall and HI/LO write pulse.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor completes IDLE->DONE without iterating.
module div_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        sign,
   input  logic        annul,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        stall,
   output logic        hilo_we,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t      state;
   logic [5:0]  cnt;
   logic [31:0] rem, quo, dvs;
   logic        neg_q, neg_r, dz;

   logic [31:0] abs_d, abs_v;
   logic [32:0] sh;
   logic        ge;
   logic [31:0] rem_nx, quo_nx;

   assign abs_d = (sign & dividend[31]) ? -dividend : dividend;
   assign abs_v = (sign & divisor[31])  ? -divisor  : divisor;

   // Shifted partial remainder can reach 33 bits; compare before subtracting so the result fits 32.
   assign sh     = {rem, quo[31]};
   assign ge     = (sh >= {1'b0, dvs});
   assign rem_nx = ge ? (sh[31:0] - dvs) : sh[31:0];
   assign quo_nx = {quo[30:0], ge};

   assign stall = ~rst & ~annul & (((state == IDLE) & start) | (state == BUSY));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         hilo_we <= 1'b0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         hilo_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !annul) begin
                  quo   <= abs_d;
                  dvs   <= abs_v;
                  rem   <= '0;
                  cnt   <= '0;
                  neg_q <= sign & (dividend[31] ^ divisor[31]);
                  neg_r <= sign & dividend[31];
                  dz    <= (divisor == 32'd0);
`ifdef DIV_ZERO_FAST_EN
                  if (divisor == 32'd0) begin
                     lo      <= 32'hFFFF_FFFF;
                     hi      <= dividend;
                     hilo_we <= 1'b1;
                     state   <= DONE;
                  end else
`endif
                  state <= BUSY;
               end
            end
            BUSY: begin
               if (annul) begin
                  state <= IDLE;
               end else begin
                  rem <= rem_nx;
                  quo <= quo_nx;
                  cnt <= cnt + 6'd1;
                  if (cnt == 6'd31) begin
                     state   <= DONE;
                     hilo_we <= 1'b1;
                     // With a zero divisor the remainder ends as |dividend|, so sign correction restores the raw dividend.
                     lo      <= dz ? 32'hFFFF_FFFF : (neg_q ? -quo_nx : quo_nx);
                     hi      <= neg_r ? -rem_nx : rem_nx;
                  end
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: results, latency, stall window, annul/reset aborts, back-to-back issue.
module tb_div_seq;

   logic        clk = 1'b0;
   logic        rst, start, sign, annul;
   logic [31:0] dividend, divisor;
   logic        stall, hilo_we;
   logic [31:0] hi, lo;

`ifdef DIV_ZERO_FAST_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 33;
`endif

   int n_tests = 0, n_fail = 0;
   int cyc_n, pulses, first_pulse, last_pulse, stall_cnt;
   logic        stall_now;
   logic [31:0] first_lo, first_hi;

   div_seq dut (
      .clk(clk), .rst(rst), .start(start), .sign(sign), .annul(annul),
      .dividend(dividend), .divisor(divisor),
      .stall(stall), .hilo_we(hilo_we), .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic clr();
      cyc_n = 0; pulses = 0; first_pulse = -1; last_pulse = -1; stall_cnt = 0;
   endtask

   // Inputs are set at posedge+1; sample at posedge+2, then advance to the next posedge+1.
   task automatic tick();
      #1;
      stall_now = stall;
      if (stall) stall_cnt++;
      if (hilo_we) begin
         pulses++;
         if (first_pulse < 0) begin
            first_pulse = cyc_n; first_lo = lo; first_hi = hi;
         end
         last_pulse = cyc_n;
      end
      @(posedge clk); #1;
      cyc_n++;
   endtask

   task automatic run_div(input string tag, input logic sg, input logic [31:0] dd, input logic [31:0] dv,
                          input logic [31:0] elo, input logic [31:0] ehi, input int lat);
      clr();
      sign = sg; dividend = dd; divisor = dv; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (lat + 3) tick();
      chk({tag, "_pulses"}, pulses, 1);
      chk({tag, "_lat"}, first_pulse, lat);
      chk({tag, "_stallcyc"}, stall_cnt, lat);
      chk({tag, "_lo"}, first_lo, elo);
      chk({tag, "_hi"}, first_hi, ehi);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; sign = 1'b0; annul = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1; dividend = 32'd5; divisor = 32'd1;
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_we", hilo_we, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      rst = 1'b0; start = 1'b0;
      @(posedge clk); #1;

      run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
      run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
      run_div("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
      run_div("divu_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 33);
      run_div("divu_z", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, ZLAT);
      run_div("div_z_neg", 1'b1, 32'h8765_4321, 32'd0, 32'hFFFF_FFFF, 32'h8765_4321, ZLAT);
      run_div("divu_1000_3", 1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 33);

      // start together with annul must not launch
      clr();
      sign = 1'b0; dividend = 32'd50; divisor = 32'd5; start = 1'b1; annul = 1'b1;
      tick();
      chk("sa_stall", stall_now, 0);
      start = 1'b0; annul = 1'b0;
      repeat (36) tick();
      chk("sa_pulses", pulses, 0);
      chk("sa_lo", lo, 32'd333);

      // annul in BUSY at cycle 10
      clr();
      sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("an_stall9", stall_now, 1);
      annul = 1'b1;
      tick();
      chk("an_stall10", stall_now, 0);
      annul = 1'b0;
      tick();
      chk("an_stall11", stall_now, 0);
      repeat (35) tick();
      chk("an_pulses", pulses, 0);
      chk("an_lo", lo, 32'd333);
      chk("an_hi", hi, 32'd1);

      // synchronous reset at cycle 20
      clr();
      sign = 1'b0; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      rst = 1'b1;
      tick();
      chk("rs_stall20", stall_now, 0);
      rst = 1'b0;
      repeat (40) tick();
      chk("rs_pulses", pulses, 0);
      chk("rs_lo", lo, 0);
      chk("rs_hi", hi, 0);

      // start held through DONE, next DIVU 9/3 at cycle 34
      clr();
      sign = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
      repeat (34) tick();
      dividend = 32'd9; divisor = 32'd3;
      tick();
      start = 1'b0;
      repeat (36) tick();
      chk("bb_pulses", pulses, 2);
      chk("bb_first", first_pulse, 33);
      chk("bb_last", last_pulse, 67);
      chk("bb_lo1", first_lo, 32'd14);
      chk("bb_lo2", lo, 32'd3);
      chk("bb_hi2", hi, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
